// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_pkg
// Purpose  : Shared definitions for the two-port RAM arbiter: FSM state
//            encoding, RAM depth and requester port identifiers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int RAM_DEPTH = 256;
  // Word-address bits that cover the RAM; default for the arbiter decode.
  localparam int c_RAM_ABITS = $clog2(RAM_DEPTH);

  localparam logic c_PORT0 = 1'b0;  // pipeline MEM stage
  localparam logic c_PORT1 = 1'b1;  // loader / debug requester

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-way round-robin picker. A lone request wins outright; under
//            contention the port that was not granted last wins.
// Ports    : req[1:0]  - request vector (bit n = port n)
//            lastGrant - id of the port granted most recently
//            grantId   - id of the winning port (meaningless if req == 0)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic       grantId
);

  always_comb begin
    grantId = c_PORT0;
    if (req == 2'b11) begin
      grantId = ~lastGrant;
    end else if (req[1]) begin
      grantId = c_PORT1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Arbitrates two requesters onto one single-ported, combinational-
//            read data RAM. Each transaction takes IDLE -> ACCESS -> RESP,
//            i.e. one transaction per three cycles.
// Ports    : clk, reset            - clock, async active-high reset
//            req/we/addr/wdata{0,1}- requester inputs (held until ack)
//            ack/err/rdata{0,1}    - completion pulse, range error, read data
//            memRead, memWrite     - RAM strobes (ACCESS only)
//            addrIn, dataIn        - RAM address / write data (0 when idle)
//            dataOut               - RAM read data
//            busy                  - FSM not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = c_RAM_ABITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] addrIn,
  output logic [31:0] dataIn,
  input  logic [31:0] dataOut,
  output logic        busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_id;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_last;
  logic        r_err;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_grant;
  logic        w_any_req;
  logic        w_in_range;

  rr_pick2 u_pick (
    .req       ({req1, req0}),
    .lastGrant (r_last),
    .grantId   (w_grant)
  );

  assign w_any_req  = req0 | req1;
  // Shift form stays valid even when ADDR_BITS covers the whole word.
  assign w_in_range = ((r_addr >> ADDR_BITS) == 32'd0);

  assign busy   = (r_state != ST_IDLE);
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs. RAM bus is only driven for in-range accesses so
  // an erroneous request never touches the RAM.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    addrIn      = 32'd0;
    dataIn      = 32'd0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_RESP;
        if (w_in_range) begin
          addrIn   = r_addr;
          memRead  = ~r_we;
          memWrite = r_we;
          dataIn   = r_we ? r_wdata : 32'd0;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
        if (r_id == c_PORT1) begin
          ack1 = 1'b1;
          err1 = r_err;
        end else begin
          ack0 = 1'b1;
          err0 = r_err;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, round-robin history, error flag and per-port read data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id     <= c_PORT0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_last   <= c_PORT1;  // port 0 wins the first contention
      r_err    <= 1'b0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_id    <= w_grant;
            r_last  <= w_grant;
            r_we    <= (w_grant == c_PORT1) ? we1    : we0;
            r_addr  <= (w_grant == c_PORT1) ? addr1  : addr0;
            r_wdata <= (w_grant == c_PORT1) ? wdata1 : wdata0;
          end
        end
        ST_ACCESS: begin
          r_err <= ~w_in_range;
          if (!r_we) begin
            // An errored read clears the port's read data.
            if (r_id == c_PORT1) begin
              r_rdata1 <= w_in_range ? dataOut : 32'd0;
            end else begin
              r_rdata0 <= w_in_range ? dataOut : 32'd0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a local RAM and a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        memRead, memWrite, busy;
  logic [31:0] addrIn, dataIn, dataOut;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .memRead(memRead), .memWrite(memWrite),
    .addrIn(addrIn), .dataIn(dataIn), .dataOut(dataOut), .busy(busy)
  );

  // RAM owned by the bench; contents mirrored by ref_mem in the model.
  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        do_init;

  assign dataOut = ram[addrIn[7:0]];

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
    end else if (memWrite) begin
      ram[addrIn[7:0]] <= dataIn;
    end
  end

  // Bus-level invariant monitor and strobe counters.
  int viol = 0;
  int n_rd = 0;
  int n_wr = 0;
  always @(negedge clk) begin
    if (memRead)  n_rd <= n_rd + 1;
    if (memWrite) n_wr <= n_wr + 1;
    if ((memRead && memWrite) ||
        (!busy && (memRead || memWrite || addrIn != 0 || dataIn != 0)) ||
        (!memWrite && dataIn != 0) ||
        (!memRead && !memWrite && addrIn != 0) ||
        (ack0 && ack1) ||
        ((ack0 || ack1) && (memRead || memWrite)) ||
        (err0 && !ack0) || (err1 && !ack1))
      viol <= viol + 1;
  end

  // Reference model state.
  logic        m_last;
  logic [31:0] m_rd [2];
  int          passed = 0;
  int          total  = 0;

  function automatic logic pick(input logic [1:0] m);
    if (m == 2'b11) return ~m_last;
    return m[1];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_port(input logic p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic wait_ack(output logic got, output logic port, output int cyc);
    got = 1'b0; port = 1'b0; cyc = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick();
      cyc++;
      if (ack0 || ack1) begin got = 1'b1; port = ack1; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    m_last = 1'b1; m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // One uncontended transaction started from IDLE.
  task automatic run_txn(input logic p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
    logic got, port, e, errx;
    int cyc, rd0, wr0;
    logic [31:0] exp_rd, rdx;
    e = ((a >> 8) != 0);
    exp_rd = m_rd[p];
    if (!we) exp_rd = e ? 32'd0 : ref_mem[a[7:0]];
    rd0 = n_rd; wr0 = n_wr;
    drive_port(p, 1'b1, we, a, d);
    wait_ack(got, port, cyc);
    total++;
    if (!got || port !== p || cyc != 2)
      $display("FAIL %s_ack: got=%0d port=%0d cycles=%0d, required port=%0d cycles=2", tag, got, port, cyc, p);
    else passed++;
    errx = p ? err1 : err0;
    rdx  = p ? rdata1 : rdata0;
    total++;
    if (errx !== e) $display("FAIL %s_err: got %b required %b", tag, errx, e);
    else passed++;
    total++;
    if (rdx !== exp_rd) $display("FAIL %s_rdata: got %h required %h", tag, rdx, exp_rd);
    else passed++;
    total++;
    if ((n_rd - rd0) != int'(!e && !we) || (n_wr - wr0) != int'(!e && we))
      $display("FAIL %s_strobes: rd=%0d wr=%0d required rd=%0d wr=%0d", tag,
               n_rd - rd0, n_wr - wr0, int'(!e && !we), int'(!e && we));
    else passed++;
    if (!we) m_rd[p] = exp_rd;
    else if (!e) ref_mem[a[7:0]] = d;
    m_last = p;
    drive_port(p, 1'b0, we, a, d);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if ({busy, ack0, ack1, err0, err1, memRead, memWrite} !== 7'd0 || addrIn !== 0 || dataIn !== 0)
      $display("FAIL reset_ctrl: busy=%b ack=%b%b err=%b%b rd=%b wr=%b addrIn=%h dataIn=%h, required all 0",
               busy, ack0, ack1, err0, err1, memRead, memWrite, addrIn, dataIn);
    else passed++;
    total++;
    if (rdata0 !== 0 || rdata1 !== 0)
      $display("FAIL reset_rdata: got %h %h required 0 0", rdata0, rdata1);
    else passed++;
    do_reset();
  endtask

  task automatic test_single_read();
    drive_port(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    tick();
    total++;
    if ({memRead, memWrite, busy} !== 3'b101 || addrIn !== 32'd5)
      $display("FAIL single_access: rd=%b wr=%b busy=%b addrIn=%h, required 1 0 1 5", memRead, memWrite, busy, addrIn);
    else passed++;
    tick();
    total++;
    if ({ack0, err0, ack1} !== 3'b100 || rdata0 !== 32'hDEADBEEF)
      $display("FAIL single_resp: ack0=%b err0=%b ack1=%b rdata0=%h, required 1 0 0 deadbeef", ack0, err0, ack1, rdata0);
    else passed++;
    drive_port(1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
    m_rd[0] = 32'hDEADBEEF; m_last = 1'b0;
    tick();
    total++;
    if ({ack0, busy} !== 2'b00)
      $display("FAIL single_ack_width: ack0=%b busy=%b, required 0 0", ack0, busy);
    else passed++;
  endtask

  task automatic test_write_read();
    run_txn(1'b1, 1'b1, 32'd200, 32'h12345678, "wr_p1");
    run_txn(1'b1, 1'b0, 32'd200, 32'd0, "rd_p1");
    total++;
    if (rdata1 !== 32'h12345678) $display("FAIL write_read: got %h required 12345678", rdata1);
    else passed++;
  endtask

  task automatic test_out_of_range();
    run_txn(1'b0, 1'b0, 32'h100, 32'd0, "oor_rd");
    run_txn(1'b1, 1'b1, 32'h8000_0010, 32'hCAFE0001, "oor_wr");
  endtask

  task automatic test_contention();
    logic got, port;
    int cyc;
    logic [31:0] a [2];
    do_reset();
    a[0] = $urandom_range(0, 255); a[1] = $urandom_range(0, 255);
    drive_port(1'b0, 1'b1, 1'b0, a[0], 32'd0);
    drive_port(1'b1, 1'b1, 1'b0, a[1], 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(got, port, cyc);
      total++;
      if (!got || port !== logic'(i % 2) || cyc != ((i == 0) ? 2 : 3))
        $display("FAIL contention_%0d: got=%0d port=%0d cycles=%0d, required port=%0d cycles=%0d",
                 i, got, port, cyc, i % 2, (i == 0) ? 2 : 3);
      else passed++;
      total++;
      if ((port ? rdata1 : rdata0) !== ref_mem[a[port][7:0]])
        $display("FAIL contention_data_%0d: got %h required %h", i, port ? rdata1 : rdata0, ref_mem[a[port][7:0]]);
      else passed++;
      m_last = port; m_rd[port] = ref_mem[a[port][7:0]];
    end
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_busy_ignore();
    logic got, port;
    int cyc;
    drive_port(1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
    tick();
    // Change port 0's fields and raise port 1 while the FSM is busy.
    drive_port(1'b0, 1'b1, 1'b1, 32'd20, 32'hFFFF0000);
    drive_port(1'b1, 1'b1, 1'b0, 32'd11, 32'd0);
    #1;
    total++;
    if (memRead !== 1'b1 || memWrite !== 1'b0 || addrIn !== 32'd10)
      $display("FAIL busy_ignore_bus: rd=%b wr=%b addrIn=%h, required 1 0 0000000a", memRead, memWrite, addrIn);
    else passed++;
    tick();
    total++;
    if (ack0 !== 1'b1 || rdata0 !== ref_mem[10])
      $display("FAIL busy_ignore_resp: ack0=%b rdata0=%h required 1 %h", ack0, rdata0, ref_mem[10]);
    else passed++;
    m_rd[0] = ref_mem[10]; m_last = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_ack(got, port, cyc);
    total++;
    if (!got || port !== 1'b1 || rdata1 !== ref_mem[11])
      $display("FAIL busy_loser_wait: got=%0d port=%0d rdata1=%h, required port=1 %h", got, port, rdata1, ref_mem[11]);
    else passed++;
    m_rd[1] = ref_mem[11]; m_last = 1'b1;
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_random();
    logic [1:0] mask, pending;
    logic w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic got, port, exp, e;
    logic [31:0] exp_rd;
    int cyc, rd0, wr0, nth;
    for (int t = 0; t < 40; t++) begin
      mask = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        w[p] = 1'($urandom_range(0, 1));
        a[p] = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 255));
        d[p] = $urandom;
        if (mask[p]) drive_port(logic'(p), 1'b1, w[p], a[p], d[p]);
      end
      pending = mask; nth = 0;
      while (pending != 2'b00) begin
        exp = pick(pending);
        e = ((a[exp] >> 8) != 0);
        exp_rd = w[exp] ? m_rd[exp] : (e ? 32'd0 : ref_mem[a[exp][7:0]]);
        rd0 = n_rd; wr0 = n_wr;
        wait_ack(got, port, cyc);
        total++;
        if (!got || port !== exp || cyc != ((nth == 0) ? 2 : 3) ||
            (exp ? err1 : err0) !== e || (exp ? rdata1 : rdata0) !== exp_rd ||
            (exp ? rdata0 : rdata1) !== m_rd[~exp] ||
            (n_rd - rd0) != int'(!e && !w[exp]) || (n_wr - wr0) != int'(!e && w[exp]))
          $display("FAIL random_%0d_%0d: got=%0d port=%0d cyc=%0d err=%b%b rdata=%h/%h, required port=%0d err=%b rdata=%h other=%h",
                   t, nth, got, port, cyc, err1, err0, rdata1, rdata0, exp, e, exp_rd, m_rd[~exp]);
        else passed++;
        if (!w[exp]) m_rd[exp] = exp_rd;
        else if (!e) ref_mem[a[exp][7:0]] = d[exp];
        m_last = exp;
        drive_port(exp, 1'b0, w[exp], a[exp], d[exp]);
        pending[exp] = 1'b0;
        nth++;
        if (!got) pending = 2'b00;
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    logic got, port;
    int cyc;
    drive_port(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    tick();
    total++;
    if (memRead !== 1'b1) $display("FAIL midop_access: memRead=%b required 1", memRead);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, ack0, ack1, err0, err1, memRead, memWrite} !== 7'd0 || addrIn !== 0 || dataIn !== 0 ||
        rdata0 !== 0 || rdata1 !== 0)
      $display("FAIL midop_reset_outputs: busy=%b ack0=%b rd=%b addrIn=%h rdata0=%h rdata1=%h, required all 0",
               busy, ack0, memRead, addrIn, rdata0, rdata1);
    else passed++;
    tick();
    total++;
    if (ack0 !== 1'b0) $display("FAIL midop_no_ack: ack0=%b required 0", ack0);
    else passed++;
    reset = 1'b0;
    m_last = 1'b1; m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    wait_ack(got, port, cyc);
    total++;
    if (!got || port !== 1'b0 || cyc != 2 || rdata0 !== ref_mem[5])
      $display("FAIL midop_reserve: got=%0d port=%0d cycles=%0d rdata0=%h, required port=0 cycles=2 %h",
               got, port, cyc, rdata0, ref_mem[5]);
    else passed++;
    m_rd[0] = ref_mem[5]; m_last = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_invariants();
    total++;
    if (viol != 0) $display("FAIL bus_invariants: %0d violating cycles, required 0", viol);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[5] = 32'hDEADBEEF;
    do_init = 1'b1;
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    do_init = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_out_of_range();
    test_contention();
    test_busy_ignore();
    test_random();
    test_reset_midop();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
